// File: rtl/exec_pkg.sv
// Shared constants for the EX stage: ALU op codes, mul/div FSM encoding, default widths.
// Optional divider: define EXEC_DIVIDER_EN to route DIVU/REMU through the iterative unit.
package exec_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_REG_ADDR_WIDTH = 5;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_NOR   = 4'h5;
    localparam logic [3:0] ALU_SLT   = 4'h6;
    localparam logic [3:0] ALU_SLL   = 4'h7;
    localparam logic [3:0] ALU_SRL   = 4'h8;
    localparam logic [3:0] ALU_SRA   = 4'h9;
    localparam logic [3:0] ALU_MUL   = 4'hA;
    localparam logic [3:0] ALU_MULHU = 4'hB;
    localparam logic [3:0] ALU_DIVU  = 4'hC;
    localparam logic [3:0] ALU_REMU  = 4'hD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Iterative-unit op: bit1 selects divide, bit0 selects the high accumulator half.
    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    // True for op codes executed by the iterative unit in this build.
    function automatic logic isMulDivOp(input logic [3:0] op);
`ifdef EXEC_DIVIDER_EN
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
    endfunction

endpackage

// File: rtl/iterative_muldiv.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one accumulator pair.
// Optional divider: EXEC_DIVIDER_EN adds the DIV state and subtract datapath.
module iterative_muldiv
    import exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [1:0]            opIn,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic [CNT_W-1:0]      counter;
    logic [1:0]            opHeld;
    logic [DATA_WIDTH-1:0] accHi;
    logic [DATA_WIDTH-1:0] accLo;
    logic [DATA_WIDTH-1:0] opBHeld;
    logic [DATA_WIDTH:0]   mulSum;
    logic                  lastStep;

    assign lastStep = (counter == CNT_W'(DATA_WIDTH - 1));
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opBHeld} : '0);

`ifdef EXEC_DIVIDER_EN
    logic [DATA_WIDTH:0] divShift;
    logic [DATA_WIDTH:0] divDiff;
    assign divShift = {accHi, accLo[DATA_WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opBHeld};
`endif

    // FSM state register
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) state <= ST_IDLE;
        else         state <= stateNext;
    end

    // FSM next-state
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
`ifdef EXEC_DIVIDER_EN
                    stateNext = opIn[1] ? ST_DIV : ST_MUL;
`else
                    stateNext = ST_MUL;
`endif
                end
            end
            ST_MUL:  if (lastStep) stateNext = ST_DONE;
`ifdef EXEC_DIVIDER_EN
            ST_DIV:  if (lastStep) stateNext = ST_DONE;
`endif
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // Operand latch and one iteration step per edge
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            counter <= '0;
            opHeld  <= '0;
            accHi   <= '0;
            accLo   <= '0;
            opBHeld <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        counter <= '0;
                        opHeld  <= opIn;
                        accHi   <= '0;
                        accLo   <= operandA;
                        opBHeld <= operandB;
                    end
                end
                ST_MUL: begin
                    {accHi, accLo} <= {mulSum, accLo[DATA_WIDTH-1:1]};
                    counter        <= counter + CNT_W'(1);
                end
`ifdef EXEC_DIVIDER_EN
                ST_DIV: begin
                    if (!divDiff[DATA_WIDTH]) begin
                        accHi <= divDiff[DATA_WIDTH-1:0];
                        accLo <= {accLo[DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        accHi <= divShift[DATA_WIDTH-1:0];
                        accLo <= {accLo[DATA_WIDTH-2:0], 1'b0};
                    end
                    counter <= counter + CNT_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    // Low half holds product-low / quotient, high half holds product-high / remainder.
`ifdef EXEC_DIVIDER_EN
    assign result = opHeld[0] ? accHi : accLo;
`else
    assign result = (opHeld == MD_MULHU) ? accHi : accLo;
`endif

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: single-cycle ALU, iterative mul/div, EX/MEM boundary register.
// Optional divider: EXEC_DIVIDER_EN (otherwise DIVU/REMU are reserved codes giving 0).
module execute_stage
    import exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      validIn,
    input  logic [3:0]                aluOp,
    input  logic                      aluSrc,
    input  logic [DATA_WIDTH-1:0]     regData1,
    input  logic [DATA_WIDTH-1:0]     regData2,
    input  logic [DATA_WIDTH-1:0]     immediate,
    input  logic [REG_ADDR_WIDTH-1:0] rtIn,
    input  logic [REG_ADDR_WIDTH-1:0] rdIn,
    input  logic                      regDst,
    input  logic [1:0]                writeBackControlIn,
    input  logic [1:0]                memAccessControlIn,
    output logic                      stall,
    output logic [1:0]                writeBackControlOut,
    output logic [1:0]                memAccessControlOut,
    output logic [DATA_WIDTH-1:0]     resultOut,
    output logic [DATA_WIDTH-1:0]     writeDataOut,
    output logic [REG_ADDR_WIDTH-1:0] rdOut
);
    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]     operandB;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [SHAMT_W-1:0]        shamt;
    logic [REG_ADDR_WIDTH-1:0] destReg;
    logic                      issue;
    logic                      mdBusy;
    logic                      mdDone;
    logic [DATA_WIDTH-1:0]     mdResult;
    logic [1:0]                wbHeld;
    logic [1:0]                memHeld;
    logic [REG_ADDR_WIDTH-1:0] rdHeld;
    logic [DATA_WIDTH-1:0]     writeDataHeld;

    assign operandB = aluSrc ? immediate : regData2;
    assign shamt    = operandB[SHAMT_W-1:0];
    assign destReg  = regDst ? rdIn : rtIn;
    // Issue only from idle; the DONE cycle never accepts a new multi-cycle op.
    assign issue    = validIn & isMulDivOp(aluOp) & ~mdBusy & ~mdDone;
    assign stall    = resetN & (issue | mdBusy);

    iterative_muldiv #(.DATA_WIDTH(DATA_WIDTH)) uMulDiv (
        .clk      (clk),
        .resetN   (resetN),
        .start    (issue),
        .opIn     ({aluOp[2], aluOp[0]}),
        .operandA (regData1),
        .operandB (operandB),
        .busy     (mdBusy),
        .done     (mdDone),
        .result   (mdResult)
    );

    // Single-cycle ALU
    always_comb begin
        aluResult = '0;
        case (aluOp)
            ALU_ADD: aluResult = regData1 + operandB;
            ALU_SUB: aluResult = regData1 - operandB;
            ALU_AND: aluResult = regData1 & operandB;
            ALU_OR:  aluResult = regData1 | operandB;
            ALU_XOR: aluResult = regData1 ^ operandB;
            ALU_NOR: aluResult = ~(regData1 | operandB);
            ALU_SLT: aluResult = DATA_WIDTH'($signed(regData1) < $signed(operandB));
            ALU_SLL: aluResult = regData1 << shamt;
            ALU_SRL: aluResult = regData1 >> shamt;
            ALU_SRA: aluResult = $unsigned($signed(regData1) >>> shamt);
            default: aluResult = '0;
        endcase
    end

    // Controls of the in-flight multi-cycle op, replayed when its result emerges
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            wbHeld        <= '0;
            memHeld       <= '0;
            rdHeld        <= '0;
            writeDataHeld <= '0;
        end else if (issue) begin
            wbHeld        <= writeBackControlIn;
            memHeld       <= memAccessControlIn;
            rdHeld        <= destReg;
            writeDataHeld <= regData2;
        end
    end

    // EX/MEM boundary register
    always_ff @(negedge clk or negedge resetN) begin
        if (!resetN) begin
            resultOut           <= '0;
            writeDataOut        <= '0;
            rdOut               <= '0;
            writeBackControlOut <= '0;
            memAccessControlOut <= '0;
        end else if (mdDone) begin
            resultOut           <= mdResult;
            writeDataOut        <= writeDataHeld;
            rdOut               <= rdHeld;
            writeBackControlOut <= wbHeld;
            memAccessControlOut <= memHeld;
        end else if (validIn && !issue && !mdBusy) begin
            resultOut           <= aluResult;
            writeDataOut        <= regData2;
            rdOut               <= destReg;
            writeBackControlOut <= writeBackControlIn;
            memAccessControlOut <= memAccessControlIn;
        end else begin
            resultOut           <= '0;
            writeDataOut        <= '0;
            rdOut               <= '0;
            writeBackControlOut <= '0;
            memAccessControlOut <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (state updates on falling clock edge).
// Expected DIVU/REMU behaviour follows EXEC_DIVIDER_EN.
module tb_execute_stage;

    logic        clk;
    logic        resetN;
    logic        validIn;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic [31:0] regData1;
    logic [31:0] regData2;
    logic [31:0] immediate;
    logic [4:0]  rtIn;
    logic [4:0]  rdIn;
    logic        regDst;
    logic [1:0]  writeBackControlIn;
    logic [1:0]  memAccessControlIn;
    logic        stall;
    logic [1:0]  writeBackControlOut;
    logic [1:0]  memAccessControlOut;
    logic [31:0] resultOut;
    logic [31:0] writeDataOut;
    logic [4:0]  rdOut;

    int checks = 0;
    int errors = 0;

    localparam int MUL_STALL = 33;
`ifdef EXEC_DIVIDER_EN
    localparam int DIV_STALL = 33;
`else
    localparam int DIV_STALL = 0;
`endif

    execute_stage dut (
        .clk                 (clk),
        .resetN              (resetN),
        .validIn             (validIn),
        .aluOp               (aluOp),
        .aluSrc              (aluSrc),
        .regData1            (regData1),
        .regData2            (regData2),
        .immediate           (immediate),
        .rtIn                (rtIn),
        .rdIn                (rdIn),
        .regDst              (regDst),
        .writeBackControlIn  (writeBackControlIn),
        .memAccessControlIn  (memAccessControlIn),
        .stall               (stall),
        .writeBackControlOut (writeBackControlOut),
        .memAccessControlOut (memAccessControlOut),
        .resultOut           (resultOut),
        .writeDataOut        (writeDataOut),
        .rdOut               (rdOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic setInstr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic src, input logic dst,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic [1:0] wb, input logic [1:0] mem);
        validIn            = 1'b1;
        aluOp              = op;
        regData1           = a;
        regData2           = b;
        immediate          = imm;
        aluSrc             = src;
        regDst             = dst;
        rtIn               = rt;
        rdIn               = rd;
        writeBackControlIn = wb;
        memAccessControlIn = mem;
    endtask

    task automatic setIdle();
        validIn            = 1'b0;
        aluOp              = 4'h0;
        regData1           = 32'h0;
        regData2           = 32'h0;
        immediate          = 32'h0;
        aluSrc             = 1'b0;
        regDst             = 1'b0;
        rtIn               = 5'h0;
        rdIn               = 5'h0;
        writeBackControlIn = 2'b00;
        memAccessControlIn = 2'b00;
    endtask

    // Hold inputs until an edge with stall low consumes them; outputs then belong to this op.
    task automatic runInstr(output int stallCycles, output int bubbleErr);
        logic s;
        stallCycles = 0;
        bubbleErr   = 0;
        s           = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            s = stall;
            if (s) stallCycles++;
            @(negedge clk);
            #1;
            if (!s) return;
            if (resultOut != 0 || writeDataOut != 0 || rdOut != 0 ||
                writeBackControlOut != 0 || memAccessControlOut != 0) bubbleErr++;
        end
        checkVal("timeout", 32'(s), 32'd0);
    endtask

    task automatic doOp(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic src,
                        input logic dst, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] wb, input logic [1:0] mem,
                        input logic [31:0] expRes, input int expStall);
        int sc;
        int be;
        setInstr(op, a, b, imm, src, dst, rt, rd, wb, mem);
        runInstr(sc, be);
        checkVal({name, ".result"}, resultOut, expRes);
        checkVal({name, ".stall"}, 32'(sc), 32'(expStall));
        checkVal({name, ".bubble"}, 32'(be), 32'd0);
        checkVal({name, ".rd"}, 32'(rdOut), 32'(dst ? rd : rt));
        checkVal({name, ".wb"}, 32'(writeBackControlOut), 32'(wb));
        checkVal({name, ".mem"}, 32'(memAccessControlOut), 32'(mem));
        checkVal({name, ".wdata"}, writeDataOut, b);
    endtask

    initial begin
        int sc;
        int be;
        resetN = 1'b0;
        setIdle();
        #12;
        checkVal("rst.result", resultOut, 32'h0);
        checkVal("rst.rd", 32'(rdOut), 32'h0);
        checkVal("rst.ctl", 32'({writeBackControlOut, memAccessControlOut}), 32'h0);
        checkVal("rst.stall", 32'(stall), 32'h0);
        @(negedge clk);
        #1;
        resetN = 1'b1;

        // Single-cycle ALU
        doOp("add",  4'h0, 32'd5,        32'd0, 32'd7,  1'b1, 1'b1, 5'd9, 5'd3, 2'b10, 2'b00, 32'd12,       0);
        doOp("slt",  4'h6, 32'hFFFFFFFF, 32'd1, 32'd0,  1'b0, 1'b0, 5'd4, 5'd8, 2'b01, 2'b00, 32'd1,        0);
        doOp("sra",  4'h9, 32'h80000000, 32'd4, 32'd0,  1'b0, 1'b1, 5'd1, 5'd2, 2'b01, 2'b00, 32'hF8000000, 0);
        doOp("sub",  4'h1, 32'd0,        32'd1, 32'd0,  1'b0, 1'b1, 5'd1, 5'd7, 2'b11, 2'b00, 32'hFFFFFFFF, 0);
        doOp("sll",  4'h7, 32'd1,        32'd0, 32'h24, 1'b1, 1'b0, 5'd6, 5'd0, 2'b00, 2'b10, 32'h10,       0);
        doOp("srl",  4'h8, 32'h80000000, 32'd31,32'd0,  1'b0, 1'b0, 5'd5, 5'd0, 2'b00, 2'b01, 32'h1,        0);
        doOp("nor",  4'h5, 32'h0F0F0000, 32'h0000F0F0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd9, 2'b00, 2'b00, 32'hF0F00F0F, 0);
        doOp("xor",  4'h4, 32'hFF00FF00, 32'h0FF00FF0, 32'd0, 1'b1, 1'b1, 5'd0, 5'd9, 2'b10, 2'b00, 32'hFF00FF00, 0);
        doOp("resv", 4'hE, 32'h12345678, 32'h9, 32'd0,  1'b0, 1'b1, 5'd0, 5'd1, 2'b10, 2'b00, 32'h0,        0);

        // Bubble
        setIdle();
        runInstr(sc, be);
        checkVal("bubble.result", resultOut, 32'h0);
        checkVal("bubble.ctl", 32'({writeBackControlOut, memAccessControlOut, rdOut}), 32'h0);

        // Multiply
        doOp("mul",    4'hA, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b1, 5'd0, 5'd10, 2'b11, 2'b00, 32'h0, MUL_STALL);
        doOp("mulhu",  4'hB, 32'h00010000, 32'h00010000, 32'd0, 1'b0, 1'b0, 5'd11, 5'd0, 2'b10, 2'b01, 32'h1, MUL_STALL);
        doOp("mulmax", 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 5'd0, 5'd12, 2'b01, 2'b00, 32'h1, MUL_STALL);
        doOp("mulhmx", 4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 5'd0, 5'd13, 2'b01, 2'b00, 32'hFFFFFFFE, MUL_STALL);

        // Divide
`ifdef EXEC_DIVIDER_EN
        doOp("divu",  4'hC, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd14, 2'b10, 2'b00, 32'd14,       DIV_STALL);
        doOp("remu",  4'hD, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd15, 2'b10, 2'b00, 32'd2,        DIV_STALL);
        doOp("divu0", 4'hC, 32'd5,   32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd16, 2'b10, 2'b00, 32'hFFFFFFFF, DIV_STALL);
        doOp("remu0", 4'hD, 32'd5,   32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd17, 2'b10, 2'b00, 32'd5,        DIV_STALL);
`else
        doOp("divu",  4'hC, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd14, 2'b10, 2'b00, 32'd0, DIV_STALL);
        doOp("remu",  4'hD, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, 5'd0, 5'd15, 2'b10, 2'b00, 32'd0, DIV_STALL);
        doOp("divu0", 4'hC, 32'd5,   32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd16, 2'b10, 2'b00, 32'd0, DIV_STALL);
        doOp("remu0", 4'hD, 32'd5,   32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd17, 2'b10, 2'b00, 32'd0, DIV_STALL);
`endif

        // Reset in the middle of a multiply
        setInstr(4'hA, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 5'd0, 5'd20, 2'b11, 2'b10);
        @(posedge clk);
        @(negedge clk);
        repeat (10) @(negedge clk);
        #1;
        checkVal("midop.stall", 32'(stall), 32'd1);
        resetN = 1'b0;
        #1;
        checkVal("abort.stall", 32'(stall), 32'd0);
        checkVal("abort.result", resultOut, 32'h0);
        checkVal("abort.ctl", 32'({writeBackControlOut, memAccessControlOut, rdOut}), 32'h0);
        setIdle();
        @(negedge clk);
        #1;
        resetN = 1'b1;
        repeat (40) begin
            @(negedge clk);
            #1;
            checkVal("abort.nopartial", resultOut | 32'(writeBackControlOut), 32'h0);
        end
        doOp("addpost", 4'h0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 5'd0, 5'd21, 2'b10, 2'b00, 32'd2, 0);

        // Back-to-back with validIn held high
        doOp("b2b.add1", 4'h0, 32'd2,  32'd3,  32'd0, 1'b0, 1'b1, 5'd0, 5'd5, 2'b01, 2'b10, 32'd5,  0);
        doOp("b2b.mul",  4'hA, 32'd3,  32'd4,  32'd0, 1'b0, 1'b1, 5'd0, 5'd6, 2'b10, 2'b00, 32'd12, MUL_STALL);
        doOp("b2b.add2", 4'h0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b1, 5'd0, 5'd7, 2'b11, 2'b01, 32'd30, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
